// File: rtl/ex_div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and ready/start levels.
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient}.
// Build option DIV_ZERO_FAST_EN: divide-by-zero skips the BY_ZERO state and is ready one cycle earlier.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? (~v + ONE_W) : v;
  endfunction

  div_state_e         state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   rem_r, quo_r, divisor_r;
  logic               neg_quo_r, neg_rem_r;
  logic [2*WIDTH-1:0] result_r;
  logic [WIDTH:0]     shifted_s, diff_s;
  logic [WIDTH-1:0]   rem_next_s, quo_next_s;
  logic               go_s, zero_div_s;

  assign go_s       = div_start & ~annul;
  assign zero_div_s = (opdata2 == ZERO_W);

  // Next-state logic; annul and a dropped start abort from any state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      DivFree: begin
        if (go_s && zero_div_s) begin
`ifdef DIV_ZERO_FAST_EN
          state_next_s = DivEnd;
`else
          state_next_s = DivByZero;
`endif
        end else if (go_s) begin
          state_next_s = DivOn;
        end else begin
          state_next_s = DivFree;
        end
      end
      DivByZero: begin
        if (!go_s) state_next_s = DivFree;
        else       state_next_s = DivEnd;
      end
      DivOn: begin
        if (!go_s)                 state_next_s = DivFree;
        else if (cnt_r == CNT_LAST) state_next_s = DivEnd;
        else                       state_next_s = DivOn;
      end
      DivEnd:  state_next_s = DivFree;
      default: state_next_s = DivFree;
    endcase
  end

  // One restoring step: shift in the next dividend bit, keep the difference if it did not go negative.
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, divisor_r};
    if (!diff_s[WIDTH]) begin
      rem_next_s = diff_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= DivFree;
    else     state_r <= state_next_s;
  end

  // Datapath: operand latch, iteration, and result load on entry to END.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      divisor_r <= ZERO_W;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_r  <= {2*WIDTH{1'b0}};
    end else begin
      case (state_r)
        DivFree: begin
          if (go_s && !zero_div_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= ZERO_W;
            quo_r     <= cond_neg(opdata1, signed_div & opdata1[WIDTH-1]);
            divisor_r <= cond_neg(opdata2, signed_div & opdata2[WIDTH-1]);
            neg_quo_r <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_r <= signed_div & opdata1[WIDTH-1];
          end
`ifdef DIV_ZERO_FAST_EN
          if (go_s && zero_div_s) result_r <= {opdata1, ONES_W};
`endif
        end
        DivByZero: begin
          if (state_next_s == DivEnd) result_r <= {opdata1, ONES_W};
        end
        DivOn: begin
          if (go_s) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r + CNT_ONE;
          end
          if (state_next_s == DivEnd)
            result_r <= {cond_neg(rem_next_s, neg_rem_r), cond_neg(quo_next_s, neg_quo_r)};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign result   = result_r;
  assign ready    = (state_r == DivEnd) ? DivResultReady : DivResultNotReady;
  // Stall depends only on the request and the FSM, never on the datapath.
  assign stallreq = div_start & (state_r != DivEnd);

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: latency, signed/unsigned results, divide-by-zero, annul and reset.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 2;
`endif

  ex_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is at posedge+1; the first sampled cycle is c0. Returns at posedge+1 of c(exp_cyc+1).
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cyc, input logic [63:0] exp_res, input bit keep);
    int ready_at, ready_cnt, stall_bad;
    logic [63:0] res_at;
    ready_at = -1; ready_cnt = 0; stall_bad = 0; res_at = '0;
    signed_div = sgn; opdata1 = a; opdata2 = b; div_start = 1'b1;
    for (int c = 0; c <= exp_cyc; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ready_cnt++;
        if (ready_at < 0) ready_at = c;
      end
      if (stallreq !== (c != exp_cyc)) stall_bad++;
      if (c == exp_cyc) res_at = result;
      @(posedge clk); #1;
    end
    chk({tag, "_ready_cycle"}, 64'(ready_at), 64'(exp_cyc));
    chk({tag, "_ready_count"}, 64'(ready_cnt), 64'd1);
    chk({tag, "_stallreq"}, 64'(stall_bad), 64'd0);
    chk({tag, "_result"}, res_at, exp_res);
    if (!keep) div_start = 1'b0;
  endtask

  initial begin
    int rdy_seen;
    logic [63:0] prev;

    rst = 1'b1; div_start = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0; annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_stallreq", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned and signed vectors
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, 1'b0);
    run_div("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 33, {32'hFFFF_FFFE, 32'd2}, 1'b0);
    run_div("divu_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, {32'd1, 32'h7FFF_FFFC}, 1'b0);

    // Divide by zero
    run_div("div_5_0", 1'b1, 32'd5, 32'd0, ZERO_LAT, {32'd5, 32'hFFFF_FFFF}, 1'b0);

    // Annul at c10, restart at c11 completes 33 cycles later
    prev = result;
    rdy_seen = 0;
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; div_start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) annul = 1'b1;
      @(negedge clk);
      if (ready === 1'b1) rdy_seen++;
      @(posedge clk); #1;
    end
    annul = 1'b0;
    chk("annul_no_ready", 64'(rdy_seen), 64'd0);
    chk("annul_result_kept", result, prev);
    run_div("annul_restart", 1'b0, 32'd1000, 32'd3, 33, {32'd1, 32'd333}, 1'b0);

    // Back-to-back with start held across the boundary
    run_div("b2b_divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF}, 1'b1);
    run_div("b2b_div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, 1'b0);

    // Reset at c5 of a divide
    signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; div_start = 1'b1;
    rdy_seen = 0;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) rst = 1'b1;
      @(negedge clk);
      if (ready === 1'b1) rdy_seen++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_stall_hi", {63'd0, stallreq}, 64'd1);
    chk("rst_mid_no_ready", 64'(rdy_seen), 64'd0);
    @(posedge clk); #1;
    div_start = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_lo", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Fresh divide after reset recovery
    run_div("post_rst_divu", 1'b0, 32'd50, 32'd5, 33, {32'd0, 32'd10}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
